// File: rtl/hazard_tracker.sv
// Decode-side hazard controller: tracks in-flight GRF producers and the mult/div
// busy window, producing the stall request and per-read-port forwarding selects.
module hazard_tracker #(
  parameter int NUM_READ    = 2,
  parameter int NUM_SLOT    = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [NUM_READ*5-1:0] dec_read_addr,
  input  logic [NUM_READ*2-1:0] dec_read_stage,
  input  logic [4:0]            dec_write_addr,
  input  logic [1:0]            dec_write_stage,
  input  logic                  dec_md_start,
  input  logic                  dec_md_is_div,
  input  logic                  dec_md_use,
  output logic                  stall,
  output logic [NUM_READ*2-1:0] fwd_sel,
  output logic                  md_busy
);

  // Slot index j holds the producer that is j+1 stages past decode.
  logic [NUM_SLOT-1:0] r_slot_valid;
  logic [4:0]          r_slot_addr   [NUM_SLOT];
  logic [1:0]          r_slot_wstage [NUM_SLOT];
  logic [CNT_W-1:0]    r_md_cnt;

  logic [NUM_READ-1:0]   w_port_haz;
  logic [NUM_READ*2-1:0] w_port_fwd;
  logic                  w_md_busy;
  logic                  w_md_haz;
  logic                  w_stall;

  // Youngest-match search per read port and its readiness test.
  always_comb begin
    logic [4:0] w_ra;
    logic [1:0] w_rs;
    logic [1:0] w_k;
    logic [1:0] w_ws;
    logic       w_hit;
    logic       w_m;
    w_port_haz = '0;
    w_port_fwd = '0;
    w_ra  = 5'd0;
    w_rs  = 2'd0;
    w_k   = 2'd0;
    w_ws  = 2'd0;
    w_hit = 1'b0;
    w_m   = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      w_ra  = dec_read_addr[5*i +: 5];
      w_rs  = dec_read_stage[2*i +: 2];
      w_hit = 1'b0;
      w_k   = 2'd0;
      w_ws  = 2'd0;
      // Scan oldest to youngest so the youngest match overwrites older ones.
      for (int j = NUM_SLOT - 1; j >= 0; j--) begin
        w_m   = r_slot_valid[j] && (r_slot_addr[j] == w_ra) &&
                (w_ra != 5'd0) && (w_rs != 2'd3);
        w_hit = w_hit | w_m;
        w_k   = w_m ? 2'(j + 1) : w_k;
        w_ws  = w_m ? r_slot_wstage[j] : w_ws;
      end
      if (w_hit && (({1'b0, w_k} + {1'b0, w_rs}) <= {1'b0, w_ws})) begin
        w_port_haz[i] = 1'b1;
      end else begin
        w_port_fwd[2*i +: 2] = w_k;
      end
    end
  end

  assign w_md_busy = (r_md_cnt != {CNT_W{1'b0}});
  assign w_md_haz  = dec_valid && (dec_md_start || dec_md_use) && w_md_busy;
  assign w_stall   = dec_valid && ((|w_port_haz) || w_md_haz);

  assign stall   = w_stall;
  assign fwd_sel = w_stall ? {(NUM_READ*2){1'b0}} : w_port_fwd;
  assign md_busy = w_md_busy;

  // Producer scoreboard: a stalled or invalid decode inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_valid <= '0;
      for (int j = 0; j < NUM_SLOT; j++) begin
        r_slot_addr[j]   <= 5'd0;
        r_slot_wstage[j] <= 2'd0;
      end
    end else begin
      r_slot_valid[0]  <= !w_stall && dec_valid && (dec_write_addr != 5'd0);
      r_slot_addr[0]   <= dec_write_addr;
      r_slot_wstage[0] <= dec_write_stage;
      for (int j = 1; j < NUM_SLOT; j++) begin
        r_slot_valid[j]  <= r_slot_valid[j-1];
        r_slot_addr[j]   <= r_slot_addr[j-1];
        r_slot_wstage[j] <= r_slot_wstage[j-1];
      end
    end
  end

  // Mult/div busy counter: issue load beats decrement, saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= {CNT_W{1'b0}};
    end else if (!w_stall && dec_valid && dec_md_start) begin
      r_md_cnt <= dec_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed pipeline scenarios plus random
// traffic, checked against a per-register "last writer" timestamp model.
module tb_hazard_tracker;

  localparam int NR = 2;
  localparam int NS = 3;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_valid;
  logic [NR*5-1:0] dec_read_addr;
  logic [NR*2-1:0] dec_read_stage;
  logic [4:0]    dec_write_addr;
  logic [1:0]    dec_write_stage;
  logic          dec_md_start;
  logic          dec_md_is_div;
  logic          dec_md_use;
  logic          stall;
  logic [NR*2-1:0] fwd_sel;
  logic          md_busy;

  always #5 clk = ~clk;

  hazard_tracker #(
    .NUM_READ(NR), .NUM_SLOT(NS), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_read_addr(dec_read_addr), .dec_read_stage(dec_read_stage),
    .dec_write_addr(dec_write_addr), .dec_write_stage(dec_write_stage),
    .dec_md_start(dec_md_start), .dec_md_is_div(dec_md_is_div),
    .dec_md_use(dec_md_use), .stall(stall), .fwd_sel(fwd_sel), .md_busy(md_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lw_cyc [32];
  int lw_ws  [32];
  int md_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      lw_cyc[r] = -100;
      lw_ws[r]  = 0;
    end
    md_ready = 0;
  endtask

  task automatic drive(input logic v, input int ra0, input int rs0, input int ra1,
                       input int rs1, input int wa, input int ws, input logic mds,
                       input logic mdd, input logic mdu);
    dec_valid       = v;
    dec_read_addr   = {5'(ra1), 5'(ra0)};
    dec_read_stage  = {2'(rs1), 2'(rs0)};
    dec_write_addr  = 5'(wa);
    dec_write_stage = 2'(ws);
    dec_md_start    = mds;
    dec_md_is_div   = mdd;
    dec_md_use      = mdu;
  endtask

  // Distance in cycles from the last writer decides match, readiness and slot.
  function automatic void port_exp(input int ra, input int rs, output logic haz, output int fwd);
    int d;
    haz = 1'b0;
    fwd = 0;
    d = cyc - lw_cyc[ra];
    if (ra != 0 && rs != 3 && d >= 1 && d <= NS) begin
      if (d + rs <= lw_ws[ra]) haz = 1'b1;
      else fwd = d;
    end
  endfunction

  task automatic step(output logic obs_stall);
    logic h0, h1, busy, es;
    int f0, f1;
    port_exp(int'(dec_read_addr[4:0]), int'(dec_read_stage[1:0]), h0, f0);
    port_exp(int'(dec_read_addr[9:5]), int'(dec_read_stage[3:2]), h1, f1);
    busy = (cyc < md_ready);
    es = dec_valid && (h0 || h1 || ((dec_md_start || dec_md_use) && busy));
    #2;
    check("stall", {31'd0, stall}, {31'd0, es});
    check("fwd0", {30'd0, fwd_sel[1:0]}, es ? 32'd0 : f0);
    check("fwd1", {30'd0, fwd_sel[3:2]}, es ? 32'd0 : f1);
    check("md_busy", {31'd0, md_busy}, {31'd0, busy});
    obs_stall = stall;
    @(posedge clk);
    if (dec_valid && !es) begin
      if (dec_write_addr != 5'd0) begin
        lw_cyc[dec_write_addr] = cyc;
        lw_ws[dec_write_addr]  = int'(dec_write_stage);
      end
      if (dec_md_start) md_ready = cyc + (dec_md_is_div ? DC : MC) + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic md_window(input logic is_div, output int n);
    logic s;
    n = 0;
    drive(1'b1, 0, 3, 0, 3, 0, 0, 1'b1, is_div, 1'b0);
    step(s);
    drive(1'b1, 0, 3, 0, 3, 12, 1, 1'b0, 1'b0, 1'b1);
    s = 1'b1;
    for (int i = 0; i < 20 && s; i++) begin
      step(s);
      if (s) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s1, s2;
    int n;
    logic v, mds, mdd, mdu;
    int ra0, rs0, ra1, rs1, wa, ws;

    model_reset();
    drive(1'b0, 0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd", {28'd0, fwd_sel}, 32'd0);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    reset = 1'b0;

    // Load-use: one stall, then forward from slot 2.
    drive(1'b1, 0, 3, 0, 3, 8, 2, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 8, 1, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0); step(s1); step(s2);
    check("loaduse_seq", {30'd0, s1, s2}, 32'd2);

    // ALU result into a branch, then with one unrelated instruction between.
    drive(1'b1, 0, 3, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 0, 3, 9, 0, 0, 0, 1'b0, 1'b0, 1'b0); step(s1); step(s2);
    check("branch_seq", {30'd0, s1, s2}, 32'd2);
    drive(1'b1, 0, 3, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 3, 1, 0, 3, 4, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 0, 3, 9, 0, 0, 0, 1'b0, 1'b0, 1'b0); step(s1);
    check("branch_gap", {31'd0, s1}, 32'd0);

    // Youngest producer wins.
    drive(1'b1, 0, 3, 0, 3, 10, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 0, 3, 0, 3, 10, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 10, 1, 10, 1, 11, 1, 1'b0, 1'b0, 1'b0); step(s1);

    // $0 writes never tracked; bubbles never stall.
    drive(1'b1, 0, 3, 0, 3, 0, 2, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 0, 1, 0, 0, 5, 1, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b1, 0, 3, 0, 3, 8, 2, 1'b0, 1'b0, 1'b0); step(s1);
    drive(1'b0, 8, 0, 8, 1, 8, 2, 1'b0, 1'b0, 1'b1); step(s1);
    check("bubble_nostall", {31'd0, s1}, 32'd0);

    md_window(1'b1, n);
    check("div_stall_cycles", n, DC);
    md_window(1'b0, n);
    check("mult_stall_cycles", n, MC);

    // Reset asserted between edges while a divide has 6 cycles left.
    drive(1'b1, 0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b0); step(s1);
    drive(1'b1, 0, 3, 0, 3, 12, 1, 1'b0, 1'b0, 1'b1);
    repeat (4) step(s1);
    drive(1'b1, 12, 1, 0, 3, 13, 1, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_fwd", {28'd0, fwd_sel}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    step(s1);
    check("post_rst_issue", {31'd0, s1}, 32'd0);

    // Random traffic; a stalled instruction is held until it issues.
    s1 = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (!s1) begin
        v   = ($urandom % 10) != 0;
        ra0 = $urandom_range(0, 3); rs0 = $urandom_range(0, 3);
        ra1 = $urandom_range(0, 3); rs1 = $urandom_range(0, 3);
        wa  = $urandom_range(0, 3); ws  = $urandom_range(0, 2);
        mds = ($urandom % 12) == 0;
        mdd = $urandom_range(0, 1) == 1;
        mdu = ($urandom % 8) == 0;
        drive(v, ra0, rs0, ra1, rs1, wa, ws, mds, mdd, mdu);
      end
      step(s1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Parametrised hazard/stall and forwarding controller for the MIPS pipeline, sitting beside the decode stage.
- It consumes per-instruction Tuse/Tnew information from the decoder: the stage in which each GRF source is needed, and the stage by whose end the destination is produced.
- It tracks in-flight producers in a shift-register scoreboard and tracks the multi-cycle mult/div unit with a busy counter.
- Each cycle it produces the stall signal and per-read-port forwarding selects.

Parameters:
- NUM_READ, 2, number of GRF read ports checked.
- NUM_SLOT, 3, in-flight pipeline slots after decode (1=E, 2=M, 3=W).
- MULT_CYCLES, 5, busy cycles loaded on mult/multu issue.
- DIV_CYCLES, 10, busy cycles loaded on div/divu issue.
- CNT_W, 4, busy counter width; must hold DIV_CYCLES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- dec_valid  input  1  decode holds a real instruction (0 = bubble).
- dec_read_addr  input  NUM_READ*5  GRF source addresses; port i is at bits [5i+4:5i].
- dec_read_stage  input  NUM_READ*2  use stage per port: 0=D, 1=E, 2=M, 3=none.
- dec_write_addr  input  5  destination register (0 = no write).
- dec_write_stage  input  2  stage by whose end the result exists: 0=D, 1=E, 2=M.
- dec_md_start  input  1  instruction is mult/multu/div/divu.
- dec_md_is_div  input  1  selects DIV_CYCLES when dec_md_start is high.
- dec_md_use  input  1  instruction is mfhi/mflo/mthi/mtlo.
- stall  output  1  freeze PC and the F/D register; insert a bubble into E.
- fwd_sel  output  NUM_READ*2  per port: 0 = GRF value, k = forward from slot k (1..3).
- md_busy  output  1  busy counter is non-zero.

Behaviour:
- Scoreboard: each slot k holds {valid, addr, wstage}.
  - When stall is 0: slot1 <= decode entry, which is valid only if dec_valid and dec_write_addr != 0.
  - When stall is 1: slot1 <= invalid (bubble).
  - In both cases: slot k+1 <= slot k; the oldest slot is discarded.
- Slot match for port i: slot valid, slot addr == read_addr_i, read_addr_i != 0, and read_stage_i != 3.
- The youngest matching slot (smallest k) is authoritative; older matches are ignored.
- Data hazard on port i: youngest match at slot k with k + read_stage_i <= wstage. In that case the result is not ready by the consumer's use stage, so the port stalls.
- fwd_sel_i:
  - equals k of the youngest match when that match causes no hazard;
  - is 0 when there is no match;
  - is don't-care while stall is 1, and is driven to 0 while stall is 1.
- MD counter:
  - When stall is 0 and dec_valid and dec_md_start: load MULT_CYCLES or DIV_CYCLES.
  - Otherwise, decrement when non-zero; saturate at 0.
  - md_busy = (counter != 0).
- MD hazard: dec_valid && (dec_md_start || dec_md_use) && md_busy.
- stall = dec_valid && (any port data hazard || MD hazard). It is combinational from the inputs and current state, with no extra latency.
- A stalled instruction re-evaluates every cycle; it issues in the first cycle its hazards clear.
- Simultaneous events:
  - An MD load on issue takes priority over decrement.
  - A stalled md_start never loads the counter.
- Reset, including mid-operation: all slots invalid, counter 0, stall=0, fwd_sel=0, md_busy=0. Outputs reflect this immediately (asynchronous).
- dec_valid=0 never stalls; it inserts an invalid slot1 entry.
- A write to $0 is never recorded, so it never forwards or stalls.

Test Plan:
- Load-use: lw $t0 (wstage=2), then add reading $t0 at stage 1 → stall=1 for exactly 1 cycle, then fwd_sel=2 (slot2) on that port.
- Branch after ALU: addu $t1 (wstage=1), then beq reading $t1 at stage 0 → 1 stall cycle, then fwd_sel=2. With one unrelated instruction between them: no stall, fwd_sel=2.
- Youngest wins: ori $t2 at slot2 and addu $t2 at slot1, consumer at stage 1 → stall=0, fwd_sel=1.
- MD busy: div issued, then mflo the next cycle → stall held exactly 10 cycles (DIV_CYCLES) then released. Same with mult → 5 cycles. md_busy=1 throughout.
- $0 and bubbles: producer writes $0, consumer reads $0 → fwd_sel=0 and no stall. dec_valid=0 with a hazardous encoding → stall=0.
- Reset mid-div (counter=6), with reset asserted asynchronously between clock edges → md_busy=0, stall=0, and all slots invalid immediately. The first instruction after reset sees no hazards.
